// File: rtl/gpio_arb_pkg.sv
// rtl/gpio_arb_pkg.sv - shared state encoding and GPIO register map for the GPIO arbiter
package gpio_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  localparam logic [1:0] GPIO_DIR  = 2'b00;
  localparam logic [1:0] GPIO_DATA = 2'b01;

endpackage

// File: rtl/gpio_arbiter_if.sv
// rtl/gpio_arbiter_if.sv - requester and GPIO bus signals of the two-master GPIO arbiter
interface gpio_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
);
  logic              m0_req,   m1_req;
  logic              m0_we,    m1_we;
  logic [ADDR_W-1:0] m0_addr,  m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_lock,  m1_lock;
  logic              m0_ack,   m1_ack;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              gpio_cs;
  logic              gpio_we;
  logic [ADDR_W-1:0] gpio_addr;
  logic [DATA_W-1:0] gpio_wdata;
  logic [DATA_W-1:0] gpio_rdata;
  logic              owner;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
           m0_wdata, m1_wdata, m0_lock, m1_lock, gpio_rdata,
    output m0_ack, m1_ack, m0_rdata, m1_rdata,
           gpio_cs, gpio_we, gpio_addr, gpio_wdata, owner
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
           m0_wdata, m1_wdata, m0_lock, m1_lock, gpio_rdata,
    input  m0_ack, m1_ack, m0_rdata, m1_rdata,
           gpio_cs, gpio_we, gpio_addr, gpio_wdata, owner
  );

endinterface

// File: rtl/gpio_arb_rr.sv
// rtl/gpio_arb_rr.sv - combinational two-way round-robin picker with eligibility mask
module gpio_arb_rr (
  input  logic [1:0] req_i,
  input  logic       owner_i,
  input  logic [1:0] mask_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  logic [1:0] elig;

  // On a tie the requester that did not own the bus last wins.
  always_comb begin
    elig        = req_i & mask_i;
    gnt_valid_o = |elig;
    gnt_idx_o   = (elig == 2'b11) ? ~owner_i : elig[1];
  end

endmodule

// File: rtl/gpio_arbiter.sv
// rtl/gpio_arbiter.sv - two-master GPIO register arbiter; GPIO_ARB_LOCK_EN enables ownership lock
module gpio_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
) (
  input logic           clk,
  input logic           rst,
  gpio_arbiter_if.slave bus
);

`ifdef GPIO_ARB_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              lock_q, lock_d;
  logic              held_q, held_d;
  logic              cs_q, cs_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        mask;
  logic              gnt_valid, gnt_idx;

  // A held lock restricts eligibility to the most recent grantee.
  assign mask = held_q ? (owner_q ? 2'b10 : 2'b01) : 2'b11;

  gpio_arb_rr u_rr (
    .req_i       ({bus.m1_req, bus.m0_req}),
    .owner_i     (owner_q),
    .mask_i      (mask),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    lock_d   = lock_q;
    held_d   = held_q;
    cs_d     = 1'b0;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack_d    = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_d = ST_ISSUE;
          owner_d = gnt_idx;
          cs_d    = 1'b1;
          if (gnt_idx) begin
            we_d    = bus.m1_we;
            addr_d  = bus.m1_addr;
            wdata_d = bus.m1_wdata;
            lock_d  = bus.m1_lock;
          end else begin
            we_d    = bus.m0_we;
            addr_d  = bus.m0_addr;
            wdata_d = bus.m0_wdata;
            lock_d  = bus.m0_lock;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_ACK;
        ack_d   = owner_q ? 2'b10 : 2'b01;
        if (owner_q) rdata1_d = bus.gpio_rdata;
        else         rdata0_d = bus.gpio_rdata;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        held_d  = LockEn & lock_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b1;
      lock_q   <= 1'b0;
      held_q   <= 1'b0;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      lock_q   <= lock_d;
      held_q   <= held_d;
      cs_q     <= cs_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack_q    <= ack_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign bus.gpio_cs    = cs_q;
  assign bus.gpio_we    = we_q;
  assign bus.gpio_addr  = addr_q;
  assign bus.gpio_wdata = wdata_q;
  assign bus.m0_ack     = ack_q[0];
  assign bus.m1_ack     = ack_q[1];
  assign bus.m0_rdata   = rdata0_q;
  assign bus.m1_rdata   = rdata1_q;
  assign bus.owner      = owner_q;

endmodule

// File: tb/tb_gpio_arbiter.sv
// tb/tb_gpio_arbiter.sv - randomized scoreboard bench for gpio_arbiter with transaction-level model
module tb_gpio_arbiter;
  import gpio_arb_pkg::*;

`ifdef GPIO_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef struct {
    bit          we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    bit          lock;
  } txn_t;

  typedef struct {
    int          cyc;
    bit          we;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } cs_t;

  typedef struct {
    int          cyc;
    int          idx;
    logic [31:0] rdata;
  } ack_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpio_arbiter_if #(.DATA_W(32), .ADDR_W(2)) bus ();

  gpio_arbiter #(.DATA_W(32), .ADDR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // GPIO device: DATA reads return the pins, every other address is a plain register.
  logic [31:0] pins = 32'h0;
  logic [31:0] dev_regs [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  logic [31:0] mdl_regs [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

  assign bus.gpio_rdata = (bus.gpio_addr == GPIO_DATA) ? pins : dev_regs[bus.gpio_addr];

  always @(posedge clk) begin
    if (bus.gpio_cs === 1'b1 && bus.gpio_we === 1'b1) dev_regs[bus.gpio_addr] <= bus.gpio_wdata;
  end

  txn_t q0[$];
  txn_t q1[$];
  cs_t  exp_cs[$];
  ack_t exp_ack[$];

  int          cyc = 0;
  bit          rst_edge = 1'b0;
  bit          m_owner = 1'b1;
  bit          m_held = 1'b0;
  bit          m_hidx = 1'b0;
  int          m_free = 0;
  int          tests = 0;
  int          fails = 0;
  int          to_cnt = 0;
  bit          final_req = 1'b0;
  bit          final_done = 1'b0;
  logic [31:0] exp_rd [2] = '{32'h0, 32'h0};

  // Reference model: an access takes three edges; pending requests are arbitrated at the first free edge.
  always @(posedge clk) begin
    bit          p0, p1, k;
    txn_t        t;
    logic [31:0] rd;
    cs_t         c;
    ack_t        a;
    cyc      = cyc + 1;
    rst_edge = rst;
    if (rst) begin
      m_owner = 1'b1;
      m_held  = 1'b0;
      m_free  = cyc + 1;
    end else if (cyc >= m_free) begin
      p0 = (q0.size() > 0) && (!m_held || !m_hidx);
      p1 = (q1.size() > 0) && (!m_held || m_hidx);
      if (p0 || p1) begin
        k = (p0 && p1) ? !m_owner : p1;
        if (k) t = q1.pop_front();
        else   t = q0.pop_front();
        rd = (t.addr == GPIO_DATA) ? pins : mdl_regs[t.addr];
        if (t.we) mdl_regs[t.addr] = t.wdata;
        c.cyc = cyc; c.we = t.we; c.addr = t.addr; c.wdata = t.wdata;
        exp_cs.push_back(c);
        a.cyc = cyc + 1; a.idx = int'(k); a.rdata = rd;
        exp_ack.push_back(a);
        m_owner = k;
        m_held  = LOCK_EN && t.lock;
        m_hidx  = k;
        m_free  = cyc + 3;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s cyc=%0d: got %0h, required %0h", nm, cyc, got, want);
    end
  endtask

  // Monitor: samples mid-cycle and pops whatever the model expects for this cycle.
  always @(negedge clk) begin
    bit       cs_e;
    bit [1:0] ack_e;
    cs_t      c;
    ack_t     a;
    if (cyc >= 1) begin
      if (rst_edge) begin
        while (exp_cs.size() > 0 && exp_cs[$].cyc >= cyc) c = exp_cs.pop_back();
        while (exp_ack.size() > 0 && exp_ack[$].cyc >= cyc) a = exp_ack.pop_back();
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        chk("rst_gpio_addr", 32'(bus.gpio_addr), 32'h0);
        chk("rst_gpio_wdata", bus.gpio_wdata, 32'h0);
      end
      cs_e = 1'b0;
      if (exp_cs.size() > 0 && exp_cs[0].cyc == cyc) begin
        c    = exp_cs.pop_front();
        cs_e = 1'b1;
      end
      chk("gpio_cs", 32'(bus.gpio_cs), 32'(cs_e));
      if (cs_e) begin
        chk("gpio_we", 32'(bus.gpio_we), 32'(c.we));
        chk("gpio_addr", 32'(bus.gpio_addr), 32'(c.addr));
        chk("gpio_wdata", bus.gpio_wdata, c.wdata);
      end else begin
        chk("gpio_we_idle", 32'(bus.gpio_we), 32'h0);
      end
      ack_e = 2'b00;
      if (exp_ack.size() > 0 && exp_ack[0].cyc == cyc) begin
        a = exp_ack.pop_front();
        ack_e[a.idx] = 1'b1;
        exp_rd[a.idx] = a.rdata;
      end
      chk("m0_ack", 32'(bus.m0_ack), 32'(ack_e[0]));
      chk("m1_ack", 32'(bus.m1_ack), 32'(ack_e[1]));
      chk("m0_rdata", bus.m0_rdata, exp_rd[0]);
      chk("m1_rdata", bus.m1_rdata, exp_rd[1]);
      chk("owner", 32'(bus.owner), 32'(m_owner));
      if (final_req && !final_done) begin
        chk("ack_timeouts", 32'(to_cnt), 32'h0);
        chk("unserved_m0", 32'(q0.size()), 32'h0);
        chk("unserved_m1", 32'(q1.size()), 32'h0);
        chk("missing_cs", 32'(exp_cs.size()), 32'h0);
        chk("missing_ack", 32'(exp_ack.size()), 32'h0);
        final_done = 1'b1;
      end
    end
  end

  function automatic txn_t mk(bit we, logic [1:0] addr, logic [31:0] wdata, bit lock);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata; t.lock = lock;
    return t;
  endfunction

  function automatic txn_t rnd(bit lock_ok);
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.addr  = 2'($urandom_range(0, 3));
    t.wdata = $urandom;
    t.lock  = lock_ok && ($urandom_range(0, 3) == 0);
    return t;
  endfunction

  task automatic drive(input int k, input txn_t t, input bit on);
    if (k == 0) begin
      bus.m0_req = on; bus.m0_we = t.we; bus.m0_addr = t.addr;
      bus.m0_wdata = t.wdata; bus.m0_lock = t.lock;
    end else begin
      bus.m1_req = on; bus.m1_we = t.we; bus.m1_addr = t.addr;
      bus.m1_wdata = t.wdata; bus.m1_lock = t.lock;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Raise req with a new transaction, wait (bounded) for ack, then release unless holding.
  task automatic issue(input int k, input txn_t t, input bit hold);
    bit got;
    got = 1'b0;
    if (k == 0) q0.push_back(t);
    else        q1.push_back(t);
    drive(k, t, 1'b1);
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      #2;
      got = (k == 0) ? bus.m0_ack : bus.m1_ack;
    end
    if (!got) to_cnt++;
    if (!hold) drive(k, t, 1'b0);
  endtask

  initial begin
    txn_t t;
    drive(0, mk(1'b0, 2'd0, 32'h0, 1'b0), 1'b0);
    drive(1, mk(1'b0, 2'd0, 32'h0, 1'b0), 1'b0);
    idle(3);
    rst = 1'b0;

    // Tie straight after reset: m0 then m1.
    fork
      issue(0, mk(1'b0, GPIO_DIR, 32'h0, 1'b0), 1'b0);
      issue(1, mk(1'b0, GPIO_DIR, 32'h0, 1'b0), 1'b0);
    join
    idle(3);

    issue(0, mk(1'b1, GPIO_DIR, 32'h0000_00A0, 1'b0), 1'b0);
    idle(2);
    pins = 32'h0000_0100;
    issue(1, mk(1'b0, GPIO_DATA, 32'h0, 1'b0), 1'b0);
    idle(2);

    // Both requesters hold req continuously.
    fork
      for (int n = 0; n < 4; n++) issue(0, mk(1'b0, 2'(n), 32'h0, 1'b0), n < 3);
      for (int n = 0; n < 4; n++) issue(1, mk(1'b1, 2'(n + 2), 32'hB00 + n, 1'b0), n < 3);
    join
    idle(3);

    // Locked read followed by unlocked write while m1 waits.
    fork
      begin
        issue(0, mk(1'b0, GPIO_DATA, 32'h0, 1'b1), 1'b1);
        issue(0, mk(1'b1, 2'd2, 32'h00C0_FFEE, 1'b0), 1'b0);
      end
      issue(1, mk(1'b0, 2'd2, 32'h0, 1'b0), 1'b0);
    join
    idle(3);

    // Reset lands on the ISSUE cycle of an m0 read.
    t = mk(1'b0, 2'd3, 32'h0, 1'b0);
    q0.push_back(t);
    drive(0, t, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    drive(0, t, 1'b0);
    issue(1, mk(1'b0, 2'd3, 32'h0, 1'b0), 1'b0);
    idle(3);

    pins = $urandom;
    fork
      for (int n = 0; n < 30; n++) begin
        bit h;
        h = (n < 29) && ($urandom_range(0, 1) == 1);
        issue(0, rnd(n < 29), h);
        if (!h) idle($urandom_range(0, 3));
      end
      for (int n = 0; n < 30; n++) begin
        bit h;
        h = (n < 29) && ($urandom_range(0, 1) == 1);
        issue(1, rnd(n < 29), h);
        if (!h) idle($urandom_range(0, 3));
      end
    join

    idle(5);
    final_req = 1'b1;
    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, required completion before 300000");
    $fatal(1);
  end

endmodule

// File: doc/gpio_arbiter.md
GPIO_ARBITER -- requirements
Module: gpio_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, register data width.
REQ-002 Parameter: ADDR_W, 2, GPIO register address width.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Ports: m0_req / m1_req  input  1  requester access request, level, held until ack.
REQ-006 Ports: m0_we / m1_we  input  1  1=write, 0=read; stable while req high.
REQ-007 Ports: m0_addr / m1_addr  input  ADDR_W  GPIO register address; stable while req high.
REQ-008 Ports: m0_wdata / m1_wdata  input  DATA_W  write data; stable while req high.
REQ-009 Ports: m0_lock / m1_lock  input  1  hold ownership after this access; stable while req high.
REQ-010 Ports: m0_ack / m1_ack  output  1  one-cycle completion pulse.
REQ-011 Ports: m0_rdata / m1_rdata  output  DATA_W  registered read data, valid in ack cycle.
REQ-012 Port: gpio_cs  output  1  GPIO chip_select.
REQ-013 Port: gpio_we  output  1  GPIO write_enable.
REQ-014 Port: gpio_addr  output  ADDR_W  GPIO addr.
REQ-015 Port: gpio_wdata  output  DATA_W  GPIO write_data.
REQ-016 Port: gpio_rdata  input  DATA_W  GPIO read_data, combinational from GPIO.
REQ-017 Port: owner  output  1  index of current or most recent grantee.

Function
REQ-018 FSM states: IDLE, ISSUE, ACK; all outputs registered.
REQ-019 IDLE: at a rising edge with any eligible req high, select the grantee, latch its we/addr/wdata/lock, and go to ISSUE; otherwise remain in IDLE.
REQ-020 ISSUE: exactly one cycle with gpio_cs=1, and gpio_we/addr/wdata equal to the latched values. At the closing edge, capture gpio_rdata into the grantee's rdata register and go to ACK.
REQ-021 ACK: grantee's ack=1 for exactly one cycle, gpio_cs=0, then go to IDLE.
REQ-022 Latency: req seen at edge N gives cs high in cycle N+1 and ack high in cycle N+2; each access takes 3 cycles.
REQ-023 Requester deasserts req in the cycle after ack. If req is still high at the IDLE edge, it is a new request.
REQ-024 Simultaneous requests: round-robin; grant the requester not named in owner.
REQ-025 A single requester is always granted, regardless of owner.
REQ-026 Non-grantee rdata holds its previous value. gpio_cs, gpio_we, and ack are never high outside their defined states.
REQ-027 Write access: m*_rdata is still updated with gpio_rdata captured in ISSUE (do-not-care content, defined timing).
REQ-028 Changing a req, we, addr, or wdata input while in ISSUE or ACK has no effect on the current access.

Reset
REQ-029 Reset values: state=IDLE, gpio_cs=0, gpio_we=0, gpio_addr=0, gpio_wdata=0, m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, owner=1 (m0 wins the first tie), lock held=0.
REQ-030 rst asserted during ISSUE or ACK aborts the access: no ack is issued, and a GPIO write on that edge is not guaranteed to have occurred.

Configuration
REQ-031 Macro GPIO_ARB_LOCK_EN defined: if the grantee's latched lock=1, then after ACK only that requester is eligible in IDLE until it completes an access with lock=0. Reset releases the lock.
REQ-032 GPIO_ARB_LOCK_EN undefined: the lock inputs exist but are ignored, and arbitration is pure round-robin.

Structure
REQ-033 Package gpio_arb_pkg holds: FSM state encoding; GPIO register address constants DIR=2'b00 and DATA=2'b01.
REQ-034 Sub-module gpio_arb_rr: combinational 2-way round-robin picker (inputs: req[1:0], owner, lock mask; outputs: grant valid, grant index).

Verification
REQ-035 m0 write addr=00 wdata=0x000000A0 → gpio_cs=1 one cycle later with we=1, addr=00; m0_ack 2 cycles after request; m1_ack stays 0.
REQ-036 m1 read addr=01 with pins[8]=1 and pins[7]=0 → m1_rdata[8]=1, [7]=0 in m1_ack cycle.
REQ-037 m0 and m1 request on the same edge after reset → m0 served first, then m1; owner=0 then 1; no overlap of cs cycles.
REQ-038 Both requesters hold req continuously → grants alternate m0, m1, m0, m1 with 3-cycle spacing.
REQ-039 rst asserted during ISSUE → next cycle gpio_cs=0, no ack, state IDLE; a following m1 request is served normally.
REQ-040 GPIO_ARB_LOCK_EN: m0 read with lock=1 while m1 requests → m0 write lock=0 served next; m1 served only after that write's ack. Without the macro, m1 is served second.
